// File: rtl/tutor_pkg.sv
// Shared constants and state encoding for the math tutor and its answer streamer.
package tutor_pkg;

   // Mask width: one bit per candidate number 0..WIDTH-1.
   localparam int WIDTH        = 32;
   localparam int IDX_W        = 5;
   // The tutor produces its answer vector at this width, so both ends agree.
   localparam int TUTOR_MASK_W = WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/lsb_index_enc.sv
// Combinational priority encoder: index of the lowest set bit plus an all-zero flag.
module lsb_index_enc #(
   parameter int W  = tutor_pkg::WIDTH,
   parameter int IW = tutor_pkg::IDX_W
) (
   input  logic [W-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          zero
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx  = '0;
      zero = 1'b1;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx  = IW'(i);
            zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/multiple_list_streamer.sv
// Loads one answer mask and streams the indices of its set bits in ascending order.
module multiple_list_streamer #(
   parameter int WIDTH = tutor_pkg::WIDTH,
   parameter int IDX_W = tutor_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] mask_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_num,
   output logic             out_last,
   output logic             done,
   output logic [IDX_W:0]   count
);

   import tutor_pkg::*;

   localparam logic [WIDTH-1:0] MASK_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [IDX_W:0]   COUNT_ONE = {{IDX_W{1'b0}}, 1'b1};

   state_t             state_reg,   state_next;
   logic [WIDTH-1:0]   pending_reg, pending_next;
   logic [IDX_W:0]     count_reg,   count_next;

   logic [IDX_W-1:0]   lsb_idx;
   logic               pending_zero;
   logic [WIDTH-1:0]   pending_cleared;
   logic               pending_single;

   lsb_index_enc #(
      .W  (WIDTH),
      .IW (IDX_W)
   ) u_lsb_enc (
      .vec  (pending_reg),
      .idx  (lsb_idx),
      .zero (pending_zero)
   );

   // Dropping the lowest set bit; a result of zero means it was the last one.
   assign pending_cleared = pending_reg & (pending_reg - MASK_ONE);
   assign pending_single  = (pending_cleared == '0);

   // State, pending mask and beat counter; reset abandons any partial stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         pending_reg <= '0;
         count_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         count_reg   <= count_next;
      end
   end

   // Next-state, handshake and output decode.
   always_comb begin
      state_next   = state_reg;
      pending_next = pending_reg;
      count_next   = count_reg;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_last     = 1'b0;
      out_num      = '0;
      done         = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               pending_next = mask_in;
               count_next   = '0;
               state_next   = (mask_in != '0) ? ST_EMIT : ST_DONE;
            end
         end
         ST_EMIT: begin
            // pending is never empty here; the guard keeps a corrupted
            // state from emitting a bogus beat and steers it to DONE.
            out_valid = !pending_zero;
            out_last  = !pending_zero && pending_single;
            out_num   = lsb_idx;
            if (pending_zero) begin
               state_next = ST_DONE;
            end else if (out_ready) begin
               pending_next = pending_cleared;
               count_next   = count_reg + COUNT_ONE;
               if (pending_single) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign count = count_reg;

endmodule
